full_adder_beh: RTL and testbench
=================================

FULL_ADDER_BEH -- requirements
Module: full_adder_beh

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 1, operand width in bits (legal range 1..64).
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have input a, WIDTH bits, addend A (unsigned).
REQ-005 The block SHALL have input b, WIDTH bits, addend B (unsigned).
REQ-006 The block SHALL have input cin, 1 bit, carry-in.
REQ-007 The block SHALL have output s, WIDTH bits, registered sum.
REQ-008 The block SHALL have output c, 1 bit, registered carry-out.
REQ-009 The block SHALL have no other ports, so that a bench connecting only s, c, a, b, cin, clk and rst_n is complete.

Function
REQ-010 The block SHALL compute {c_next, s_next} = a + b + cin as a (WIDTH+1)-bit unsigned sum, with no truncation before the carry-out.
REQ-011 For each bit i, the block SHALL form s_i = a_i XOR b_i XOR k_i and k_(i+1) = a_i·b_i + k_i·(a_i XOR b_i), where k_0 = cin and c_next = k_WIDTH.
REQ-012 The block SHALL register s and c on every rising clk edge while rst_n is high, giving a latency of exactly 1 cycle from input sample to output.
REQ-013 The block SHALL accept a new operand set every cycle (throughput 1/cycle), with no handshake and no stall.
REQ-014 The block SHALL hold its outputs stable between clock edges, and input changes between edges SHALL NOT affect the outputs until the next edge.
REQ-015 The wrap-around case all-ones + all-ones + 1 SHALL give s = all-ones and c = 1.
REQ-016 The all-ones + 0 + 1 case SHALL give s = 0 and c = 1, with the carry rippling through every bit.
REQ-017 Unknown (X) inputs SHALL NOT be masked; X propagates to the affected output bits.

Reset
REQ-018 Asserting rst_n low SHALL immediately force s = 0 and c = 0, without waiting for a clock edge.
REQ-019 While rst_n is low, the outputs SHALL remain 0 regardless of clk, a, b or cin.
REQ-020 Deassertion of rst_n SHALL be treated as synchronous to clk by the integrator; the first capture is the first rising edge with rst_n high.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result, with no residual carry after release.

Structure
REQ-022 A shared package full_adder_pkg SHALL hold WIDTH_MAX = 64 and a function computing a (WIDTH+1)-bit reference sum, for use by the bench.
REQ-023 One sub-module, fa_cell, SHALL be used: a combinational 1-bit full adder (inputs a, b, ci; outputs s, co), instantiated WIDTH times in a generate ripple chain.
REQ-024 The top level SHALL contain only the ripple chain, the WIDTH-bit sum register, the 1-bit carry register and the async-reset logic.
REQ-025 The design SHALL contain no latches, no combinational path from inputs to outputs, and no initial blocks in the RTL.

Verification
REQ-026 Reset: rst_n = 0 with a = 1, b = 1, cin = 1 at WIDTH = 1 -> s = 0, c = 0 immediately and across clock edges.
REQ-027 Basic: WIDTH = 1, a = 0, b = 0, cin = 1, one edge after release -> s = 1, c = 0.
REQ-028 Exhaustive 1-bit: all 8 combinations of a, b, cin -> {c, s} equals the population count of a, b, cin, one cycle after each is applied.
REQ-029 Ripple: WIDTH = 8, a = 8'hFF, b = 8'h00, cin = 1 -> s = 8'h00, c = 1; and a = 8'hFF, b = 8'hFF, cin = 1 -> s = 8'hFF, c = 1.
REQ-030 Back-to-back: WIDTH = 8, the pairs (3,4,0), (200,100,1), (0,0,0) on consecutive edges -> s/c = (7,0), (45,1), (0,0) on the following consecutive edges.
REQ-031 Mid-stream reset: assert rst_n low between two operand updates -> outputs are 0 at once, and the first post-release edge shows only the newly sampled sum.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants and a reference sum for the registered ripple-carry adder.
// The reference function is intended for bench-side cross-checks.
package full_adder_pkg;

    localparam int WIDTH_MAX = 64;

    // Full-precision unsigned sum; operands narrower than WIDTH_MAX are zero-extended by the caller.
    function automatic logic [WIDTH_MAX:0] ref_sum(
        input logic [WIDTH_MAX-1:0] a,
        input logic [WIDTH_MAX-1:0] b,
        input logic                 cin
    );
        ref_sum = {1'b0, a} + {1'b0, b} + {{WIDTH_MAX{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; one link of the ripple chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_beh.sv
// WIDTH-bit ripple-carry adder with registered sum and carry-out (1-cycle latency).
// Reset asynchronously clears both registers.
module full_adder_beh
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("full_adder_beh: WIDTH out of range");
    end

    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s_next;

    assign k[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (k[i]),
            .s  (s_next[i]),
            .co (k[i+1])
        );
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= '0;
            c <= 1'b0;
        end else begin
            s <= s_next;
            c <= k[WIDTH];
        end
    end

endmodule

// File: tb/tb_full_adder_beh.sv
// Scoreboard bench for full_adder_beh at WIDTH=1 and WIDTH=8 with directed vectors.
// Stimulus pushes expected {c,s}; monitors pop and compare one cycle after capture.
module tb_full_adder_beh;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, v1 = 1'b0;
    logic [7:0] a8 = '0,   b8 = '0;
    logic       cin8 = 1'b0, v8 = 1'b0;

    logic       s1, c1;
    logic [7:0] s8;
    logic       c8;

    logic       vq1, vq8;
    logic [8:0] q1[$];
    logic [8:0] q8[$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    full_adder_beh #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .s     (s1),
        .c     (c1)
    );

    full_adder_beh #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .s     (s8),
        .c     (c8)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bench-side "valid" shadow: marks which edges captured a scored vector.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq1 <= 1'b0;
            vq8 <= 1'b0;
        end else begin
            vq1 <= v1;
            vq8 <= v8;
        end
    end

    always @(negedge clk) begin
        if (vq1) begin
            if (q1.size() == 0) check("w1_underflow", {7'b0, c1, s1}, 9'h1ff);
            else check("w1_sum", {7'b0, c1, s1}, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (vq8) begin
            if (q8.size() == 0) check("w8_underflow", {c8, s8}, 9'h1ff);
            else check("w8_sum", {c8, s8}, q8.pop_front());
        end
    end

    task automatic drive1(input logic a, input logic b, input logic ci, input logic [1:0] exp);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = ci; v1 = 1'b1;
        q1.push_back({7'b0, exp});
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [8:0] exp);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = ci; v8 = 1'b1;
        q8.push_back(exp);
    endtask

    // Expected {c,s} for (a,b,cin) = idx[2:0]: the population count.
    logic [1:0] pc_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        // Reset with all inputs high: outputs clear at once and stay clear across edges.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'hff; b8 = 8'hff; cin8 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_imm_w1", {7'b0, c1, s1}, 9'h000);
        check("rst_imm_w8", {c8, s8}, 9'h000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_w1", {7'b0, c1, s1}, 9'h000);
        check("rst_hold_w8", {c8, s8}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1: basic vector then exhaustive sweep, back-to-back.
        drive1(1'b0, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            drive1(idx[2], idx[1], idx[0], pc_tab[i]);
        end
        @(negedge clk);
        v1 = 1'b0;

        // WIDTH=8: full ripple, wrap-around, then consecutive pairs.
        drive8(8'hff, 8'h00, 1'b1, {1'b1, 8'h00});
        drive8(8'hff, 8'hff, 1'b1, {1'b1, 8'hff});
        drive8(8'd3,   8'd4,   1'b0, {1'b0, 8'd7});
        drive8(8'd200, 8'd100, 1'b1, {1'b1, 8'd45});
        drive8(8'd0,   8'd0,   1'b0, {1'b0, 8'd0});
        drive8(8'h80,  8'h80,  1'b0, {1'b1, 8'h00});
        @(negedge clk);
        v8 = 1'b0;

        // Mid-stream reset: the operands in flight are discarded.
        drive8(8'd100, 8'd100, 1'b0, {1'b0, 8'd200});
        @(negedge clk);
        v8 = 1'b0;
        a8 = 8'd7; b8 = 8'd9; cin8 = 1'b1;
        #2 rst_n = 1'b0;
        q8.delete();
        #1;
        check("mid_rst_imm", {c8, s8}, 9'h000);
        @(posedge clk);
        #1;
        check("mid_rst_hold", {c8, s8}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'd5; b8 = 8'd6; cin8 = 1'b0; v8 = 1'b1;
        q8.push_back({1'b0, 8'd11});
        @(negedge clk);
        v8 = 1'b0;

        repeat (3) @(negedge clk);
        check("q1_drained", 9'(q1.size()), 9'd0);
        check("q8_drained", 9'(q8.size()), 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
